uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, minimum 4).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port rx, input, 1, meaning the asynchronous serial line; idle level is 1.
REQ-005 The block SHALL have port data_out, output, 8, meaning the last received byte.
REQ-006 The block SHALL have port data_valid, output, 1, meaning a one-cycle pulse: data_out and the error flags are valid.
REQ-007 The block SHALL have port parity_error, output, 1, meaning the received parity bit mismatched; qualified by data_valid.
REQ-008 The block SHALL have port framing_error, output, 1, meaning the stop bit was sampled 0; qualified by data_valid.
REQ-009 The block SHALL have port busy, output, 1, meaning high from start-edge detection until return to IDLE.

Function
REQ-010 Frame format SHALL be: start(0), 8 data bits LSB first, parity bit, one stop(1).
REQ-011 Expected parity SHALL be ~^data (XNOR reduction of the 8 data bits), matching the upstream transmitter.
REQ-012 rx SHALL pass through a 2-flop synchronizer; rx_s (second flop) is the only internal view of rx.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE->START SHALL occur on a falling edge of rx_s (previous 1, current 0); clk_count cleared and busy set in the same cycle.
REQ-015 In START, at clk_count==CLKS_PER_BIT/2-1, the block SHALL sample rx_s: on 0, go to DATA with clk_count=0 and bit_count=0; on 1 (glitch), go to IDLE with no output pulse.
REQ-016 In DATA, PARITY and STOP, the block SHALL sample rx_s at clk_count==CLKS_PER_BIT-1, then clear clk_count; otherwise it increments clk_count.
REQ-017 DATA SHALL shift each sample into bit position bit_count; after the sample at bit_count==7 it goes to PARITY; bit_count is 3 bits and never wraps in use.
REQ-018 PARITY SHALL store the sampled bit and go to STOP.
REQ-019 At the STOP sample, the block SHALL load data_out, set parity_error = (sampled parity != ~^data), set framing_error = (stop sample == 0), pulse data_valid for exactly one cycle, and go to IDLE.
REQ-020 data_valid SHALL be high in the cycle after the STOP sample; busy SHALL be low in that same cycle.
REQ-021 A frame with a framing error SHALL still be delivered, with data_valid=1 and framing_error=1.
REQ-022 IDLE SHALL require rx_s==1 before accepting a new edge, so a line held low (break) produces no further frames.
REQ-023 Back-to-back frames SHALL be received with zero idle bits between the stop bit and the next start bit.
REQ-024 data_out, parity_error and framing_error SHALL hold their values until the next data_valid.

Reset
REQ-025 On reset, the block SHALL set state=IDLE, clk_count=0, bit_count=0, synchronizer flops=1, data_out=0, data_valid=0, parity_error=0, framing_error=0 and busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no data_valid; reception resumes on the next falling edge after reset deasserts.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state encoding (shared with uart_transmitter), the parity function, and the CLKS_PER_BIT default.
REQ-028 One sub-module SHALL exist: uart_rx_sync, containing the 2-flop synchronizer and falling-edge detect, with reset value 1.
REQ-029 clk_count width SHALL be $clog2(CLKS_PER_BIT).

Verification (CLKS_PER_BIT=16)
REQ-030 Driving 0xA5 with parity 1 and stop 1 SHALL produce one data_valid with data_out=0xA5 and both errors 0.
REQ-031 Driving 0x07 with parity 1 (correct is 0) SHALL produce data_out=0x07 and parity_error=1.
REQ-032 Driving 0x3C with stop=0 SHALL produce framing_error=1, and no new frame while rx stays low.
REQ-033 A 4-cycle low glitch on idle rx SHALL produce no data_valid, with busy returning to 0 within 8+3 cycles.
REQ-034 Frames 0x55 then 0xFF sent back-to-back SHALL produce two data_valid pulses 11*16 cycles apart, with correct data.
REQ-035 Reset asserted during bit 4 of a frame SHALL give all outputs 0 with no data_valid, and the next clean frame 0x81 SHALL be received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg -- shared UART state encoding, parity rule and default bit timing
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity bit the transmitter appends: XNOR reduction of the data byte.
  function automatic logic expected_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync -- 2-flop synchronizer for rx plus falling-edge detect
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Reset to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = prev & ~sync;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver -- 8 data bits, XNOR parity, one stop bit, mid-bit sampling
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_next;
  logic [CW-1:0] clk_count, clk_count_next;
  logic [2:0]    bit_count, bit_count_next;
  logic [7:0]    shift, shift_next;
  logic          parity_bit, parity_bit_next;
  logic [7:0]    data_next;
  logic          valid_next;
  logic          perr_next;
  logic          ferr_next;
  logic          rx_s;
  logic          fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      clk_count     <= '0;
      bit_count     <= '0;
      shift         <= '0;
      parity_bit    <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_next;
      clk_count     <= clk_count_next;
      bit_count     <= bit_count_next;
      shift         <= shift_next;
      parity_bit    <= parity_bit_next;
      data_out      <= data_next;
      data_valid    <= valid_next;
      parity_error  <= perr_next;
      framing_error <= ferr_next;
    end
  end

  always_comb begin
    state_next      = state;
    clk_count_next  = clk_count;
    bit_count_next  = bit_count;
    shift_next      = shift;
    parity_bit_next = parity_bit;
    data_next       = data_out;
    valid_next      = 1'b0;
    perr_next       = parity_error;
    ferr_next       = framing_error;

    case (state)
      IDLE: begin
        clk_count_next = '0;
        bit_count_next = '0;
        if (fall) state_next = START;
      end

      START: begin
        // Half-bit check rejects glitches and centres later samples mid-bit.
        if (clk_count == HALF_LAST) begin
          clk_count_next = '0;
          bit_count_next = '0;
          state_next     = rx_s ? IDLE : DATA;
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end

      DATA, PARITY, STOP: begin
        if (clk_count == BIT_LAST) begin
          clk_count_next = '0;
          case (state)
            DATA: begin
              shift_next[bit_count] = rx_s;
              if (bit_count == 3'd7) state_next = PARITY;
              else                   bit_count_next = bit_count + 1'b1;
            end
            PARITY: begin
              parity_bit_next = rx_s;
              state_next      = STOP;
            end
            default: begin
              data_next  = shift;
              perr_next  = (parity_bit != expected_parity(shift));
              ferr_next  = ~rx_s;
              valid_next = 1'b1;
              state_next = IDLE;
            end
          endcase
        end else begin
          clk_count_next = clk_count + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: fixed frame table, corner-case sequences, random frames
// against a bit-counting reference model.
`default_nettype none

module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int unsigned cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic        bsy;
    int unsigned at;
  } rec_t;

  rec_t got_q[$];

  always @(negedge clk)
    if (data_valid) got_q.push_back('{data_out, parity_error, framing_error, busy, cyc});

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
  endtask

  // Reference: parity bit the transmitter would send (1 when the count of ones is even).
  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic expect_frame(input string name, input logic [7:0] d, input logic pe, input logic fe);
    rec_t r;
    check({name, ".count"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check({name, ".data"}, r.d, d);
      check({name, ".parity_error"}, r.pe, pe);
      check({name, ".framing_error"}, r.fe, fe);
      check({name, ".busy_at_valid"}, r.bsy, 1'b0);
    end
    got_q.delete();
  endtask

  initial begin
    rec_t r1, r2;
    logic [7:0] d;
    logic p, s;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
    tbl[6] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1};

    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("reset.data_out", data_out, 8'h00);
    check("reset.data_valid", data_valid, 1'b0);
    check("reset.parity_error", parity_error, 1'b0);
    check("reset.framing_error", framing_error, 1'b0);
    check("reset.busy", busy, 1'b0);
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    got_q.delete();

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s);
      expect_frame($sformatf("table%0d", i), tbl[i].ed, tbl[i].epe, tbl[i].efe);
      send_bit(1'b1);
    end

    // Framing error followed by a line held low: exactly one frame delivered.
    send_frame(8'h3C, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (400) @(negedge clk);
    expect_frame("break", 8'h3C, 1'b0, 1'b1);
    check("break.busy", busy, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);

    // Short low glitch on the idle line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch.busy_seen", busy, 1'b1);
    rx = 1'b1;
    repeat (7) @(negedge clk);
    check("glitch.busy_cleared", busy, 1'b0);
    repeat (30) @(negedge clk);
    check("glitch.no_valid", got_q.size(), 0);
    got_q.delete();

    // Back-to-back frames with no idle bit between stop and start.
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_bit(1'b1);
    check("b2b.count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      r1 = got_q.pop_front();
      r2 = got_q.pop_front();
      check("b2b.data0", r1.d, 8'h55);
      check("b2b.data1", r2.d, 8'hFF);
      check("b2b.errors", {r1.pe, r1.fe, r2.pe, r2.fe}, 4'b0000);
      check("b2b.spacing", r2.at - r1.at, 11 * CPB);
    end
    got_q.delete();

    // Reset in the middle of data bit 4.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset.outputs", {data_out, data_valid, parity_error, framing_error, busy}, 12'h000);
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    check("midreset.no_valid", got_q.size(), 0);
    got_q.delete();
    send_frame(8'h81, 1'b1, 1'b1);
    expect_frame("after_reset", 8'h81, 1'b0, 1'b0);
    send_bit(1'b1);

    // Random frames against the reference model.
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom);
      p = ($urandom_range(0, 3) == 0) ? ~model_parity(d) : model_parity(d);
      s = ($urandom_range(0, 4) != 0);
      send_frame(d, p, s);
      expect_frame($sformatf("rand%0d", n), d, p != model_parity(d), !s);
      if (!s) begin
        send_bit(1'b1);
      end
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
